// File: rtl/mips_multicycle.sv
// mips_multicycle: multi-cycle 32-bit MIPS core.
// A single FSM (FETCH/DECODE/EXEC/MEM/WB/HALT) shares one ALU and one unified
// memory port. The memory port uses a req/ready handshake, so the memory may
// insert any number of wait cycles.
// Supported: add/sub/and/or/slt, lw, sw, addi, beq, j.
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   mem_req/mem_we        request valid / write enable (held while mem_req=1)
//   mem_addr/mem_wdata    byte address (ADDR_W bits) / write data
//   mem_rdata/mem_ready   read data / completes the current request
//   pc                    PC register
//   ula_result            ALUOut register
//   halted                core is in HALT
module mips_multicycle #(
  parameter int unsigned        ADDR_W          = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC        = '0,
  parameter bit                 HALT_ON_ILLEGAL = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] pc,
  output logic [31:0]       ula_result,
  output logic              halted
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t      state;
  logic [31:0] ir;
  logic [31:0] a_reg;
  logic [31:0] b_reg;
  logic [31:0] regs [32];

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs, rt, rd, wb_dest;
  logic [31:0] imm_sext;
  logic [31:0] pc32;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] eff_addr;
  logic [31:0] r_res;
  logic        r_legal;
  logic        illegal;

  assign opcode        = ir[31:26];
  assign rs            = ir[25:21];
  assign rt            = ir[20:16];
  assign rd            = ir[15:11];
  assign funct         = ir[5:0];
  assign imm_sext      = {{16{ir[15]}}, ir[15:0]};
  assign pc32          = 32'(pc);
  // pc already points past the branch, so this is PC+4-relative as in MIPS.
  assign branch_target = pc32 + {imm_sext[29:0], 2'b00};
  assign jump_target   = {pc32[31:28], ir[25:0], 2'b00};
  assign eff_addr      = a_reg + imm_sext;
  assign wb_dest       = (opcode == OP_RTYPE) ? rd : rt;

  always_comb begin
    r_res   = '0;
    r_legal = 1'b1;
    case (funct)
      FN_ADD:  r_res = a_reg + b_reg;
      FN_SUB:  r_res = a_reg - b_reg;
      FN_AND:  r_res = a_reg & b_reg;
      FN_OR:   r_res = a_reg | b_reg;
      FN_SLT:  r_res = {31'b0, $signed(a_reg) < $signed(b_reg)};
      default: r_legal = 1'b0;
    endcase
    case (opcode)
      OP_RTYPE:                          illegal = !r_legal;
      OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: illegal = 1'b0;
      default:                           illegal = 1'b1;
    endcase
  end

  // Memory outputs are registered; every transition into FETCH or MEM raises
  // the request in the same edge so zero-wait memory costs no extra cycle.
  // Only the first fetch after reset spends one cycle raising mem_req.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_FETCH;
      pc         <= RESET_PC;
      ir         <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      ula_result <= '0;
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      halted     <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (mem_req && mem_ready) begin
            ir      <= mem_rdata;
            pc      <= pc + ADDR_W'(4);
            mem_req <= 1'b0;
            state   <= S_DECODE;
          end else if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
          end
        end
        S_DECODE: begin
          a_reg      <= regs[rs];
          b_reg      <= regs[rt];
          ula_result <= branch_target;
          if (illegal && HALT_ON_ILLEGAL) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (illegal) begin
            state <= S_FETCH; mem_req <= 1'b1; mem_we <= 1'b0; mem_addr <= pc;
          end else begin
            case (opcode)
              OP_RTYPE: begin
                ula_result <= r_res;
                state      <= S_WB;
              end
              OP_ADDI: begin
                ula_result <= eff_addr;
                state      <= S_WB;
              end
              OP_LW, OP_SW: begin
                ula_result <= eff_addr;
                state      <= S_MEM;
                mem_req    <= 1'b1;
                mem_we     <= (opcode == OP_SW);
                mem_addr   <= ADDR_W'(eff_addr);
                mem_wdata  <= b_reg;
              end
              OP_BEQ: begin
                state   <= S_FETCH;
                mem_req <= 1'b1;
                mem_we  <= 1'b0;
                if (a_reg == b_reg) begin
                  pc       <= ADDR_W'(ula_result);
                  mem_addr <= ADDR_W'(ula_result);
                end else begin
                  mem_addr <= pc;
                end
              end
              OP_J: begin
                pc       <= ADDR_W'(jump_target);
                mem_addr <= ADDR_W'(jump_target);
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                state    <= S_FETCH;
              end
              default: begin
                state <= S_FETCH; mem_req <= 1'b1; mem_we <= 1'b0; mem_addr <= pc;
              end
            endcase
          end
        end
        S_MEM: begin
          if (mem_req && mem_ready) begin
            if (mem_we) begin
              state    <= S_FETCH;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= pc;
            end else begin
              ula_result <= mem_rdata;
              mem_req    <= 1'b0;
              state      <= S_WB;
            end
          end
        end
        S_WB: begin
          if (wb_dest != 5'd0) regs[wb_dest] <= ula_result;
          state    <= S_FETCH;
          mem_req  <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= pc;
        end
        S_HALT: begin
          mem_req <= 1'b0;
          halted  <= 1'b1;
        end
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle.sv
// Self-checking bench for mips_multicycle: table-driven ALU vectors plus
// directed sequences for reset, latency, wait states, control flow, $0,
// illegal opcodes and reset during a stalled memory request.
module tb_mips_multicycle;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req, mem_we, mem_ready, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc, ula_result;

  localparam logic [31:0] HALT_I = 32'hFC00_0000;

  int unsigned mode = 0;   // 0: always ready, 1: ready every 3rd cycle, 2: writes stall
  int unsigned cyc  = 0;
  int          n_pass = 0;
  int          n_total = 0;

  logic [31:0] prog    [512];
  logic [31:0] dmem    [512];
  logic        written [512];
  logic [31:0] wr_addr [16];
  logic [31:0] wr_data [16];
  logic [31:0] fe_addr [16];
  int          wr_cnt = 0, fe_cnt = 0, tot_wr = 0;
  logic [8:0]  idx;

  logic        hold = 1'b0;
  logic        h_we;
  logic [31:0] h_addr, h_wdata;
  int          stab_errs = 0, stalls = 0;

  always #5 clock = ~clock;

  mips_multicycle #(.ADDR_W(32), .RESET_PC(32'h0), .HALT_ON_ILLEGAL(1'b1)) dut (
    .clock(clock), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .pc(pc), .ula_result(ula_result), .halted(halted)
  );

  assign idx       = mem_addr[10:2];
  assign mem_rdata = written[idx] ? dmem[idx] : prog[idx];
  assign mem_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 2) : !mem_we;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (reset) begin
      wr_cnt <= 0;
      fe_cnt <= 0;
      for (int i = 0; i < 512; i++) written[i] <= 1'b0;
    end else if (mem_req && mem_ready) begin
      if (mem_we) begin
        dmem[idx]    <= mem_wdata;
        written[idx] <= 1'b1;
        if (wr_cnt < 16) begin
          wr_addr[wr_cnt[3:0]] <= mem_addr;
          wr_data[wr_cnt[3:0]] <= mem_wdata;
        end
        wr_cnt <= wr_cnt + 1;
        tot_wr <= tot_wr + 1;
      end else begin
        if (fe_cnt < 16) fe_addr[fe_cnt[3:0]] <= mem_addr;
        fe_cnt <= fe_cnt + 1;
      end
    end
  end

  // A pending request must stay up with unchanged address/data/direction.
  always @(negedge clock) begin
    if (hold && (!mem_req || mem_addr != h_addr || mem_we != h_we || mem_wdata != h_wdata))
      stab_errs <= stab_errs + 1;
    if (mem_req && !mem_ready) stalls <= stalls + 1;
    hold    <= mem_req && !mem_ready && !reset;
    h_addr  <= mem_addr;
    h_we    <= mem_we;
    h_wdata <= mem_wdata;
  end

  function automatic logic [31:0] r_type(input logic [5:0] fn, input logic [4:0] rd,
                                         input logic [4:0] rs, input logic [4:0] rt);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 512; i++) prog[i] = HALT_I;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    tick();
  endtask

  task automatic wait_halt(input string name, input int bound);
    int n = 0;
    while (!halted && n < bound) begin
      tick();
      n++;
    end
    check(name, {31'b0, halted}, 32'd1);
  endtask

  task automatic run_prog(input string name);
    apply_reset();
    reset = 1'b0;
    wait_halt(name, 400);
  endtask

  typedef struct {
    string       name;
    logic [31:0] op_instr;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int st0, se0, tw0, n;

    vecs[0]  = '{"add_5_m3",   r_type(6'h20, 5'd3, 5'd1, 5'd2), 16'd5,     16'hFFFD, 32'h0000_0002};
    vecs[1]  = '{"sub_5_m3",   r_type(6'h22, 5'd3, 5'd1, 5'd2), 16'd5,     16'hFFFD, 32'h0000_0008};
    vecs[2]  = '{"sub_m3_5",   r_type(6'h22, 5'd3, 5'd1, 5'd2), 16'hFFFD,  16'd5,    32'hFFFF_FFF8};
    vecs[3]  = '{"and_12_10",  r_type(6'h24, 5'd3, 5'd1, 5'd2), 16'd12,    16'd10,   32'h0000_0008};
    vecs[4]  = '{"or_12_10",   r_type(6'h25, 5'd3, 5'd1, 5'd2), 16'd12,    16'd10,   32'h0000_000E};
    vecs[5]  = '{"slt_m3_5",   r_type(6'h2A, 5'd3, 5'd1, 5'd2), 16'hFFFD,  16'd5,    32'h0000_0001};
    vecs[6]  = '{"slt_5_m3",   r_type(6'h2A, 5'd3, 5'd1, 5'd2), 16'd5,     16'hFFFD, 32'h0000_0000};
    vecs[7]  = '{"slt_5_5",    r_type(6'h2A, 5'd3, 5'd1, 5'd2), 16'd5,     16'd5,    32'h0000_0000};
    vecs[8]  = '{"add_m1_m1",  r_type(6'h20, 5'd3, 5'd1, 5'd2), 16'hFFFF,  16'hFFFF, 32'hFFFF_FFFE};
    vecs[9]  = '{"addi_min",   i_type(6'h08, 5'd1, 5'd3, 16'h8000), 16'h7FFF, 16'd0, 32'hFFFF_FFFF};
    vecs[10] = '{"and_sext",   r_type(6'h24, 5'd3, 5'd1, 5'd2), 16'hFFFF,  16'h8000, 32'hFFFF_8000};

    // Table-driven ALU vectors: load operands, run op, store $3 to 0x80.
    for (int v = 0; v < 11; v++) begin
      clear_prog();
      prog[0] = i_type(6'h08, 5'd0, 5'd1, vecs[v].a);
      prog[1] = i_type(6'h08, 5'd0, 5'd2, vecs[v].b);
      prog[2] = vecs[v].op_instr;
      prog[3] = i_type(6'h2B, 5'd0, 5'd3, 16'h0080);
      mode = 0;
      run_prog({vecs[v].name, "_halt"});
      check({vecs[v].name, "_wrcnt"}, wr_cnt, 32'd1);
      check({vecs[v].name, "_data"}, wr_data[0], vecs[v].exp);
    end

    // Reset state and zero-wait latency.
    clear_prog();
    prog[0] = i_type(6'h08, 5'd0, 5'd1, 16'd5);
    prog[1] = i_type(6'h08, 5'd0, 5'd2, 16'hFFFD);
    prog[2] = r_type(6'h20, 5'd3, 5'd1, 5'd2);
    prog[3] = r_type(6'h2A, 5'd4, 5'd2, 5'd1);
    prog[4] = i_type(6'h2B, 5'd0, 5'd3, 16'h0080);
    prog[5] = i_type(6'h2B, 5'd0, 5'd4, 16'h0084);
    mode = 0;
    apply_reset();
    check("rst_pc", pc, 32'h0);
    check("rst_req", {31'b0, mem_req}, 32'd0);
    check("rst_halted", {31'b0, halted}, 32'd0);
    check("rst_alu", ula_result, 32'h0);
    reset = 1'b0;
    tick();
    check("first_req", {31'b0, mem_req}, 32'd1);
    check("first_addr", mem_addr, 32'h0);
    repeat (11) tick();
    check("cyc12_alu", ula_result, 32'd2);
    check("cyc12_pc", pc, 32'd12);
    tick();
    check("cyc13_req", {31'b0, mem_req}, 32'd1);
    check("cyc13_addr", mem_addr, 32'd12);
    wait_halt("lat_halt", 200);
    check("lat_wrcnt", wr_cnt, 32'd2);
    check("lat_r3", wr_data[0], 32'd2);
    check("lat_r4", wr_data[1], 32'd1);

    // sw/lw with memory ready only every third cycle.
    clear_prog();
    prog[0] = i_type(6'h08, 5'd0, 5'd3, 16'd2);
    prog[1] = i_type(6'h2B, 5'd0, 5'd3, 16'h0040);
    prog[2] = i_type(6'h23, 5'd0, 5'd5, 16'h0040);
    prog[3] = i_type(6'h2B, 5'd0, 5'd5, 16'h0044);
    mode = 1;
    se0 = stab_errs;
    st0 = stalls;
    run_prog("wait_halt");
    check("wait_wrcnt", wr_cnt, 32'd2);
    check("wait_sw_addr", wr_addr[0], 32'h40);
    check("wait_sw_data", wr_data[0], 32'd2);
    check("wait_lw_addr", wr_addr[1], 32'h44);
    check("wait_lw_data", wr_data[1], 32'd2);
    check("wait_stable", stab_errs - se0, 32'd0);
    check("wait_stalled", {31'b0, stalls > st0}, 32'd1);
    mode = 0;

    // Control flow: j, beq not taken, beq taken, far j.
    clear_prog();
    prog[0]  = i_type(6'h08, 5'd0, 5'd1, 16'd1);
    prog[1]  = i_type(6'h08, 5'd0, 5'd2, 16'd2);
    prog[2]  = {6'h02, 26'h7};
    prog[7]  = i_type(6'h04, 5'd1, 5'd2, 16'd9);
    prog[8]  = i_type(6'h04, 5'd1, 5'd1, 16'd2);
    prog[11] = {6'h02, 26'h100};
    run_prog("cf_halt");
    check("cf_fecnt", fe_cnt, 32'd7);
    check("cf_f3_j", fe_addr[3], 32'h1C);
    check("cf_f4_ntaken", fe_addr[4], 32'h20);
    check("cf_f5_taken", fe_addr[5], 32'h2C);
    check("cf_f6_jfar", fe_addr[6], 32'h400);
    check("cf_pc", pc, 32'h404);

    // $0 stays zero.
    clear_prog();
    prog[0] = i_type(6'h08, 5'd0, 5'd0, 16'd7);
    prog[1] = r_type(6'h20, 5'd6, 5'd0, 5'd0);
    prog[2] = i_type(6'h2B, 5'd0, 5'd6, 16'h0080);
    run_prog("r0_halt");
    check("r0_wrcnt", wr_cnt, 32'd1);
    check("r0_data", wr_data[0], 32'd0);

    // Illegal opcode 0x3F halts right after DECODE.
    clear_prog();
    prog[0] = HALT_I;
    prog[1] = i_type(6'h2B, 5'd0, 5'd0, 16'h0080);
    apply_reset();
    reset = 1'b0;
    tick();
    tick();
    check("ill_decode_nohalt", {31'b0, halted}, 32'd0);
    tick();
    check("ill_halted", {31'b0, halted}, 32'd1);
    check("ill_noreq", {31'b0, mem_req}, 32'd0);
    repeat (5) tick();
    check("ill_stay_halted", {31'b0, halted}, 32'd1);
    check("ill_stay_noreq", {31'b0, mem_req}, 32'd0);
    check("ill_pc", pc, 32'd4);

    // Unsupported funct also halts and the next instruction never runs.
    clear_prog();
    prog[0] = r_type(6'h21, 5'd3, 5'd1, 5'd2);
    prog[1] = i_type(6'h2B, 5'd0, 5'd0, 16'h0080);
    run_prog("illfn_halt");
    check("illfn_wrcnt", wr_cnt, 32'd0);
    check("illfn_pc", pc, 32'd4);

    // Reset during a stalled store abandons it.
    clear_prog();
    prog[0] = i_type(6'h08, 5'd0, 5'd3, 16'd9);
    prog[1] = i_type(6'h2B, 5'd0, 5'd3, 16'h0040);
    mode = 2;
    apply_reset();
    reset = 1'b0;
    tw0 = tot_wr;
    n = 0;
    while (!(mem_req && mem_we) && n < 50) begin
      tick();
      n++;
    end
    check("mid_store_reached", {31'b0, mem_req && mem_we}, 32'd1);
    repeat (3) tick();
    check("mid_still_req", {31'b0, mem_req}, 32'd1);
    reset = 1'b1;
    tick();
    check("mid_rst_pc", pc, 32'h0);
    check("mid_rst_req", {31'b0, mem_req}, 32'd0);
    reset = 1'b0;
    tick();
    check("mid_fetch_req", {31'b0, mem_req}, 32'd1);
    check("mid_fetch_addr", mem_addr, 32'h0);
    check("mid_fetch_we", {31'b0, mem_we}, 32'd0);
    check("mid_no_write", tot_wr - tw0, 32'd0);
    mode = 0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
